playlist_sequencer: RTL and testbench

//   Song-queue scheduler in front of the music player. Buffers song requests from the

---
 rtl/playlist_pkg.sv | 20 ++
 rtl/song_fifo.sv | 75 +++++++
 rtl/playlist_sequencer.sv | 146 ++++++++++++++
 tb/tb_playlist_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/playlist_pkg.sv
// Shared types and helpers for the playlist sequencer: FSM state encoding and
// sizing of the inter-song gap counter.
package playlist_pkg;

  localparam int unsigned SongWDefault = 2;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPlay,
    StPaused,
    StGap
  } state_e;

  // Width needed to hold GAP_CYCLES-1; never narrower than one bit.
  function automatic int unsigned gap_cnt_w(input int unsigned gap_cycles);
    return (gap_cycles > 1) ? $clog2(gap_cycles) : 1;
  endfunction

endpackage

// File: rtl/song_fifo.sv
// Song queue with two prioritised write ports (user enqueue first, loop
// re-queue second) and a single pop; status outputs are registered.
module song_fifo #(
  parameter int unsigned SONG_W = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_push_a,
  input  logic [SONG_W-1:0]       i_data_a,
  input  logic                    i_push_b,
  input  logic [SONG_W-1:0]       i_data_b,
  input  logic                    i_pop,
  output logic [SONG_W-1:0]       o_head,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full,
  output logic                    o_empty,
  output logic                    o_drop
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [SONG_W-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [CntW-1:0]   r_count;
  logic              r_full;
  logic              r_empty;

  logic              w_pop;
  logic              w_acc_a;
  logic              w_acc_b;
  logic [CntW-1:0]   w_cnt_a;
  logic [CntW-1:0]   w_cnt_d;
  logic [PtrW-1:0]   w_wptr_b;

  // A pop in the same cycle frees a slot for either write port.
  always_comb begin
    w_pop    = i_pop && !r_empty;
    w_acc_a  = i_push_a && (!r_full || w_pop);
    w_cnt_a  = r_count - CntW'(w_pop) + CntW'(w_acc_a);
    w_acc_b  = i_push_b && (w_cnt_a < CntW'(DEPTH));
    w_cnt_d  = w_cnt_a + CntW'(w_acc_b);
    w_wptr_b = r_wptr + PtrW'(w_acc_a);
    o_drop   = (i_push_a && !w_acc_a) || (i_push_b && !w_acc_b);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_pop) r_rptr <= r_rptr + PtrW'(1);
      r_wptr  <= r_wptr + PtrW'(w_acc_a) + PtrW'(w_acc_b);
      r_count <= w_cnt_d;
      r_full  <= (w_cnt_d == CntW'(DEPTH));
      r_empty <= (w_cnt_d == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_acc_a) r_mem[r_wptr] <= i_data_a;
    if (w_acc_b) r_mem[w_wptr_b] <= i_data_b;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/playlist_sequencer.sv
// Song-queue scheduler: buffers requests, then drives the player through
// load / play / pause / gap phases with registered outputs.
module playlist_sequencer
  import playlist_pkg::*;
#(
  parameter int unsigned SONG_W     = SongWDefault,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_enq,
  input  logic [SONG_W-1:0]       i_enq_song,
  input  logic                    i_pause,
  input  logic                    i_skip,
  input  logic                    i_loop_mode,
  input  logic                    i_song_done,
  output logic                    o_play,
  output logic                    o_reset_player,
  output logic [SONG_W-1:0]       o_song,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full,
  output logic                    o_empty,
  output logic                    o_overflow
);

  localparam int unsigned GapW    = gap_cnt_w(GAP_CYCLES);
  localparam int unsigned GapLoad = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_e            r_state;
  logic [GapW-1:0]   r_gap_cnt;
  logic [SONG_W-1:0] r_song;
  logic              r_play;
  logic              r_reset_player;
  logic              r_overflow;

  state_e            w_state_d;
  logic [GapW-1:0]   w_gap_d;
  logic [SONG_W-1:0] w_song_d;
  logic              w_pop;
  logic              w_loop_push;
  logic              w_exit;
  logic [SONG_W-1:0] w_head;
  logic              w_empty;
  logic              w_drop;

  song_fifo #(
    .SONG_W (SONG_W),
    .DEPTH  (DEPTH)
  ) u_song_fifo (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_push_a (i_enq),
    .i_data_a (i_enq_song),
    .i_push_b (w_loop_push),
    .i_data_b (r_song),
    .i_pop    (w_pop),
    .o_head   (w_head),
    .o_count  (o_count),
    .o_full   (o_full),
    .o_empty  (w_empty),
    .o_drop   (w_drop)
  );

  always_comb begin
    w_state_d   = r_state;
    w_gap_d     = r_gap_cnt;
    w_song_d    = r_song;
    w_pop       = 1'b0;
    w_loop_push = 1'b0;
    w_exit      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_state_d = StLoad;
          w_pop     = 1'b1;
        end
      end
      StLoad: w_state_d = StPlay;
      StPlay: begin
        if (i_skip || i_song_done) w_exit = 1'b1;
        else if (i_pause)          w_state_d = StPaused;
      end
      StPaused: begin
        if (i_skip)       w_exit = 1'b1;
        else if (i_pause) w_state_d = StPlay;
      end
      StGap: begin
        if (r_gap_cnt == '0) begin
          if (!w_empty) begin
            w_state_d = StLoad;
            w_pop     = 1'b1;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_gap_d = r_gap_cnt - GapW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Leaving the current song: optionally re-queue it, then gap or reload.
    if (w_exit) begin
      w_loop_push = i_loop_mode;
      if (GAP_CYCLES == 0) begin
        if (!w_empty) begin
          w_state_d = StLoad;
          w_pop     = 1'b1;
        end else begin
          w_state_d = StIdle;
        end
      end else begin
        w_state_d = StGap;
        w_gap_d   = GapW'(GapLoad);
      end
    end

    if (w_pop) w_song_d = w_head;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state        <= StIdle;
      r_gap_cnt      <= '0;
      r_song         <= '0;
      r_play         <= 1'b0;
      r_reset_player <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_gap_cnt      <= w_gap_d;
      r_song         <= w_song_d;
      r_play         <= (w_state_d == StPlay);
      r_reset_player <= (w_state_d == StLoad);
      r_overflow     <= w_drop;
    end
  end

  assign o_play         = r_play;
  assign o_reset_player = r_reset_player;
  assign o_song         = r_song;
  assign o_empty        = w_empty;
  assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_playlist_sequencer.sv
// Directed bench for playlist_sequencer: DEPTH=4, GAP_CYCLES=8, SONG_W=2.
module tb_playlist_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enq = 1'b0;
  logic [1:0] enq_song = '0;
  logic       pause = 1'b0;
  logic       skip = 1'b0;
  logic       loop_mode = 1'b0;
  logic       song_done = 1'b0;
  logic       play;
  logic       reset_player;
  logic [1:0] song;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       overflow;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  playlist_sequencer #(
    .SONG_W     (2),
    .DEPTH      (4),
    .GAP_CYCLES (8)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_enq          (enq),
    .i_enq_song     (enq_song),
    .i_pause        (pause),
    .i_skip         (skip),
    .i_loop_mode    (loop_mode),
    .i_song_done    (song_done),
    .o_play         (play),
    .o_reset_player (reset_player),
    .o_song         (song),
    .o_count        (count),
    .o_full         (full),
    .o_empty        (empty),
    .o_overflow     (overflow)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(2);
    n_total++; if (play !== 1'b0) $display("FAIL rst_play got %b want 0", play); else n_pass++;
    n_total++; if (reset_player !== 1'b0) $display("FAIL rst_rp got %b want 0", reset_player);
    else n_pass++;
    n_total++; if (song !== 2'd0) $display("FAIL rst_song got %0d want 0", song); else n_pass++;
    n_total++; if (count !== 3'd0) $display("FAIL rst_count got %0d want 0", count); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL rst_empty got %b want 1", empty); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL rst_full got %b want 0", full); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL rst_ovf got %b want 0", overflow); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_first_song();
    enq = 1'b1; enq_song = 2'd1;
    cyc(1);
    enq = 1'b0;
    n_total++; if (count !== 3'd1) $display("FAIL t1_count_q got %0d want 1", count); else n_pass++;
    cyc(1);
    n_total++; if (reset_player !== 1'b1) $display("FAIL t1_rp got %b want 1", reset_player);
    else n_pass++;
    n_total++; if (play !== 1'b0) $display("FAIL t1_load_play got %b want 0", play); else n_pass++;
    n_total++; if (song !== 2'd1) $display("FAIL t1_song got %0d want 1", song); else n_pass++;
    n_total++; if (count !== 3'd0) $display("FAIL t1_count got %0d want 0", count); else n_pass++;
    cyc(1);
    n_total++; if (play !== 1'b1) $display("FAIL t1_play got %b want 1", play); else n_pass++;
    n_total++; if (reset_player !== 1'b0) $display("FAIL t1_rp_end got %b want 0", reset_player);
    else n_pass++;
  endtask

  task automatic test_sequence();
    enq = 1'b1; enq_song = 2'd2; cyc(1);
    enq_song = 2'd3; cyc(1);
    enq = 1'b0;
    n_total++; if (count !== 3'd2) $display("FAIL t2_count got %0d want 2", count); else n_pass++;
    song_done = 1'b1; cyc(1); song_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (play !== 1'b0 || reset_player !== 1'b0)
        $display("FAIL t2_gap[%0d] got play=%b rp=%b want 0,0", i, play, reset_player);
      else n_pass++;
      cyc(1);
    end
    n_total++; if (reset_player !== 1'b1) $display("FAIL t2_load2 got %b want 1", reset_player);
    else n_pass++;
    n_total++; if (song !== 2'd2) $display("FAIL t2_song2 got %0d want 2", song); else n_pass++;
    n_total++; if (count !== 3'd1) $display("FAIL t2_count2 got %0d want 1", count); else n_pass++;
    cyc(1);
    n_total++; if (play !== 1'b1) $display("FAIL t2_play2 got %b want 1", play); else n_pass++;
    song_done = 1'b1; cyc(1); song_done = 1'b0;
    cyc(8);
    n_total++; if (song !== 2'd3) $display("FAIL t2_song3 got %0d want 3", song); else n_pass++;
    cyc(1);
    song_done = 1'b1; cyc(1); song_done = 1'b0;
    cyc(8);
    n_total++; if (play !== 1'b0) $display("FAIL t2_idle_play got %b want 0", play); else n_pass++;
    n_total++; if (reset_player !== 1'b0) $display("FAIL t2_idle_rp got %b want 0", reset_player);
    else n_pass++;
    n_total++; if (song !== 2'd3) $display("FAIL t2_idle_song got %0d want 3", song); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL t2_idle_empty got %b want 1", empty);
    else n_pass++;
  endtask

  task automatic test_overflow();
    enq = 1'b1; enq_song = 2'd0; cyc(1);
    enq = 1'b0; cyc(2);
    n_total++; if (play !== 1'b1) $display("FAIL t3_play got %b want 1", play); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      enq = 1'b1; enq_song = 2'(i + 1);
      cyc(1);
      if (i == 3) begin
        n_total++; if (full !== 1'b1) $display("FAIL t3_full got %b want 1", full); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL t3_ovf_early got %b want 0", overflow);
        else n_pass++;
      end
    end
    enq = 1'b0;
    n_total++; if (overflow !== 1'b1) $display("FAIL t3_ovf got %b want 1", overflow); else n_pass++;
    n_total++; if (count !== 3'd4) $display("FAIL t3_count got %0d want 4", count); else n_pass++;
    cyc(1);
    n_total++; if (overflow !== 1'b0) $display("FAIL t3_ovf_end got %b want 0", overflow);
    else n_pass++;
  endtask

  task automatic test_pause_skip();
    pause = 1'b1; cyc(1); pause = 1'b0;
    n_total++; if (play !== 1'b0) $display("FAIL t4_paused got %b want 0", play); else n_pass++;
    n_total++; if (song !== 2'd0) $display("FAIL t4_held got %0d want 0", song); else n_pass++;
    song_done = 1'b1; cyc(1); song_done = 1'b0;
    cyc(9);
    n_total++;
    if (play !== 1'b0 || reset_player !== 1'b0 || count !== 3'd4)
      $display("FAIL t4_done_ign got play=%b rp=%b cnt=%0d want 0,0,4", play, reset_player, count);
    else n_pass++;
    pause = 1'b1; cyc(1); pause = 1'b0;
    n_total++; if (play !== 1'b1) $display("FAIL t4_resume got %b want 1", play); else n_pass++;
    skip = 1'b1; cyc(1); skip = 1'b0;
    n_total++; if (play !== 1'b0) $display("FAIL t4_skip got %b want 0", play); else n_pass++;
    cyc(8);
    n_total++;
    if (reset_player !== 1'b1 || song !== 2'd1 || count !== 3'd3)
      $display("FAIL t4_next got rp=%b song=%0d cnt=%0d want 1,1,3", reset_player, song, count);
    else n_pass++;
    cyc(1);
    pause = 1'b1; song_done = 1'b1; cyc(1); pause = 1'b0; song_done = 1'b0;
    cyc(8);
    n_total++;
    if (reset_player !== 1'b1 || song !== 2'd2 || count !== 3'd2)
      $display("FAIL t4_done_wins got rp=%b song=%0d cnt=%0d want 1,2,2", reset_player, song,
               count);
    else n_pass++;
  endtask

  task automatic test_loop();
    reset = 1'b0; cyc(2); reset = 1'b1;
    enq = 1'b1; enq_song = 2'd0; cyc(1);
    n_total++; if (count !== 3'd1) $display("FAIL t5_count_q got %0d want 1", count); else n_pass++;
    enq_song = 2'd1; cyc(1);
    enq = 1'b0;
    n_total++;
    if (count !== 3'd1 || song !== 2'd0 || reset_player !== 1'b1)
      $display("FAIL t5_enq_pop got cnt=%0d song=%0d rp=%b want 1,0,1", count, song, reset_player);
    else n_pass++;
    cyc(1);
    loop_mode = 1'b1;
    song_done = 1'b1; cyc(1); song_done = 1'b0;
    n_total++; if (count !== 3'd2) $display("FAIL t5_requeue got %0d want 2", count); else n_pass++;
    cyc(8);
    n_total++;
    if (song !== 2'd1 || count !== 3'd1)
      $display("FAIL t5_load1 got song=%0d cnt=%0d want 1,1", song, count);
    else n_pass++;
    cyc(1);
    song_done = 1'b1; cyc(1); song_done = 1'b0;
    cyc(8);
    n_total++;
    if (song !== 2'd0 || count !== 3'd1)
      $display("FAIL t5_wrap got song=%0d cnt=%0d want 0,1", song, count);
    else n_pass++;
    cyc(1);
    loop_mode = 1'b0;
  endtask

  task automatic test_reset_mid();
    enq = 1'b1; enq_song = 2'd2; cyc(1);
    enq_song = 2'd3; cyc(1);
    enq = 1'b0;
    n_total++;
    if (count !== 3'd3 || play !== 1'b1)
      $display("FAIL t6_pre got cnt=%0d play=%b want 3,1", count, play);
    else n_pass++;
    reset = 1'b0; cyc(1);
    n_total++;
    if (play !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || song !== 2'd0)
      $display("FAIL t6_rst got play=%b cnt=%0d empty=%b song=%0d want 0,0,1,0", play, count,
               empty, song);
    else n_pass++;
    reset = 1'b1; cyc(2);
    n_total++;
    if (play !== 1'b0 || reset_player !== 1'b0)
      $display("FAIL t6_idle got play=%b rp=%b want 0,0", play, reset_player);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_song();
    test_sequence();
    test_overflow();
    test_pause_skip();
    test_loop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
